// File: rtl/lerp_if.sv
// Sample/ratio input bundle and result output of the linear interpolator.
// The master drives samples and ratio; the slave (lerp) returns the result.
interface lerp_if #(
  parameter int INPUT_BITS      = 16,
  parameter int RATIO_FRAC_BITS = 8
) ();
  logic                       in_valid;
  logic [INPUT_BITS-1:0]      ina;
  logic [INPUT_BITS-1:0]      inb;
  logic [RATIO_FRAC_BITS-1:0] ratio;
  logic                       out_valid;
  logic [INPUT_BITS-1:0]      out;

  modport master (output in_valid, ina, inb, ratio, input out_valid, out);
  modport slave  (input in_valid, ina, inb, ratio, output out_valid, out);
endinterface

// File: rtl/lerp.sv
// Two-stage unsigned linear interpolator: out = floor((ina*r + inb*(R-r)) / R).
// Accepts one sample per clock; out_valid qualifies out two clocks after in_valid.
module lerp #(
  parameter int INPUT_BITS      = 16,
  parameter int RATIO_FRAC_BITS = 8
) (
  input logic   clk,
  input logic   reset_n,
  lerp_if.slave bus
);
  localparam int N = INPUT_BITS;
  localparam int F = RATIO_FRAC_BITS;
  localparam int P = N + F;

  // R - ratio needs F+1 bits so that ratio=0 yields exactly R.
  logic [F:0]   w_inv_ratio;
  logic [P-1:0] w_pa;
  logic [P:0]   w_pb;
  logic [P:0]   w_sum;

  logic [P-1:0] r_pa;
  logic [P:0]   r_pb;
  logic         r_v1;
  logic [N-1:0] r_out;
  logic         r_out_valid;

  assign w_inv_ratio = {1'b1, {F{1'b0}}} - {1'b0, bus.ratio};
  assign w_pa        = P'(bus.ina) * P'(bus.ratio);
  assign w_pb        = (P+1)'(bus.inb) * (P+1)'(w_inv_ratio);
  assign w_sum       = (P+1)'(r_pa) + r_pb;

  // NOTE: all pipeline state uses non-blocking assignments so both stages
  // sample the previous cycle's values on the same edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pa        <= '0;
      r_pb        <= '0;
      r_v1        <= 1'b0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_pa        <= w_pa;
      r_pb        <= w_pb;
      r_v1        <= bus.in_valid;
      // The sum never exceeds (2^N-1)*R, so bits [P-1:F] hold the full result.
      r_out       <= N'(w_sum >> F);
      r_out_valid <= r_v1;
    end
  end

  assign bus.out       = r_out;
  assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_lerp.sv
// Directed and randomized checks of lerp with an 8-bit and a 24-bit ratio.
module tb_lerp;
  localparam int N      = 16;
  localparam int F_N    = 8;
  localparam int F_W    = 24;
  localparam int N_RAND = 10000;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  lerp_if #(.INPUT_BITS(N), .RATIO_FRAC_BITS(F_N)) n_if ();
  lerp_if #(.INPUT_BITS(N), .RATIO_FRAC_BITS(F_W)) w_if ();

  lerp #(.INPUT_BITS(N), .RATIO_FRAC_BITS(F_N)) u_narrow (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (n_if.slave)
  );

  lerp #(.INPUT_BITS(N), .RATIO_FRAC_BITS(F_W)) u_wide (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (w_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ina;
    logic [15:0] inb;
    logic [31:0] ratio;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic        v;
    logic [15:0] en;
    logic [15:0] ew;
  } pipe_t;

  vec_t n_tbl[18];
  vec_t w_tbl[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_lerp(input logic [15:0] a, input logic [15:0] b,
                                           input logic [31:0] r, input int f);
    longint unsigned rr;
    longint unsigned s;
    rr = longint'(64'd1 << f);
    s  = longint'(a) * longint'(r) + longint'(b) * (rr - longint'(r));
    return 16'(s >> f);
  endfunction

  task automatic drive_idle();
    n_if.in_valid = 1'b0;
    n_if.ina = '0; n_if.inb = '0; n_if.ratio = '0;
    w_if.in_valid = 1'b0;
    w_if.ina = '0; w_if.inb = '0; w_if.ratio = '0;
  endtask

  initial begin
    logic [7:0] sweep[9];
    pipe_t p1, p2, pn;
    logic [31:0] rr;

    n_checks = 0;
    n_errors = 0;
    sweep = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    for (int i = 0; i < 9; i++) begin
      rr = 32'(sweep[i]);
      n_tbl[i]     = '{16'hFFFF, 16'h0000, rr, 16'h0000};
      n_tbl[i + 9] = '{16'h0000, 16'hFFFF, rr, 16'h0000};
    end
    n_tbl[0].exp  = 16'h0000; n_tbl[1].exp  = 16'h00FF; n_tbl[2].exp  = 16'h01FF;
    n_tbl[3].exp  = 16'h03FF; n_tbl[4].exp  = 16'h07FF; n_tbl[5].exp  = 16'h0FFF;
    n_tbl[6].exp  = 16'h1FFF; n_tbl[7].exp  = 16'h3FFF; n_tbl[8].exp  = 16'h7FFF;
    n_tbl[9].exp  = 16'hFFFF; n_tbl[10].exp = 16'hFEFF; n_tbl[11].exp = 16'hFDFF;
    n_tbl[12].exp = 16'hFBFF; n_tbl[13].exp = 16'hF7FF; n_tbl[14].exp = 16'hEFFF;
    n_tbl[15].exp = 16'hDFFF; n_tbl[16].exp = 16'hBFFF; n_tbl[17].exp = 16'h7FFF;
    w_tbl[0] = '{16'hFFFF, 16'h0000, 32'h0000_0000, 16'h0000};
    w_tbl[1] = '{16'hFFFF, 16'h0000, 32'h00FF_FFFF, 16'hFFFE};

    // Reset with valid-looking inputs present: everything must stay cleared.
    reset_n = 1'b0;
    n_if.in_valid = 1'b1; n_if.ina = 16'hAAAA; n_if.inb = 16'h5555; n_if.ratio = 8'h33;
    w_if.in_valid = 1'b1; w_if.ina = 16'hAAAA; w_if.inb = 16'h5555; w_if.ratio = 24'h123456;
    repeat (3) @(negedge clk);
    check("rst_n_out", 32'(n_if.out), 32'h0);
    check("rst_n_valid", 32'(n_if.out_valid), 32'h0);
    check("rst_w_out", 32'(w_if.out), 32'h0);
    check("rst_w_valid", 32'(w_if.out_valid), 32'h0);
    drive_idle();
    reset_n = 1'b1;

    // Back-to-back ratio sweeps, one new vector per clock.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        check($sformatf("sweep_out[%0d]", i - 2), 32'(n_if.out), 32'(n_tbl[i - 2].exp));
        check($sformatf("sweep_valid[%0d]", i - 2), 32'(n_if.out_valid), 32'h1);
      end
      if (i < 18) begin
        n_if.in_valid = 1'b1;
        n_if.ina = n_tbl[i].ina; n_if.inb = n_tbl[i].inb; n_if.ratio = n_tbl[i].ratio[7:0];
      end else drive_idle();
    end
    @(negedge clk);
    check("sweep_valid_drop", 32'(n_if.out_valid), 32'h0);

    // Wide ratio boundaries.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        check($sformatf("wide_out[%0d]", i - 2), 32'(w_if.out), 32'(w_tbl[i - 2].exp));
        check($sformatf("wide_valid[%0d]", i - 2), 32'(w_if.out_valid), 32'h1);
      end
      if (i < 2) begin
        w_if.in_valid = 1'b1;
        w_if.ina = w_tbl[i].ina; w_if.inb = w_tbl[i].inb; w_if.ratio = w_tbl[i].ratio[23:0];
      end else drive_idle();
    end

    // Reset mid-stream: both in-flight results must be discarded.
    @(negedge clk);
    n_if.in_valid = 1'b1; n_if.ina = 16'hFFFF; n_if.inb = 16'hFFFF; n_if.ratio = 8'h10;
    @(negedge clk);
    n_if.ina = 16'h8000; n_if.inb = 16'h8000;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_out", 32'(n_if.out), 32'h0);
    check("midrst_valid", 32'(n_if.out_valid), 32'h0);
    reset_n = 1'b1;
    drive_idle();
    @(negedge clk);
    check("postrst_out", 32'(n_if.out), 32'h0);
    check("postrst_valid0", 32'(n_if.out_valid), 32'h0);
    n_if.in_valid = 1'b1; n_if.ina = 16'h1234; n_if.inb = 16'h5678; n_if.ratio = 8'h80;
    @(negedge clk);
    check("postrst_valid1", 32'(n_if.out_valid), 32'h0);
    drive_idle();
    @(negedge clk);
    check("postrst_first_valid", 32'(n_if.out_valid), 32'h1);
    check("postrst_first_out", 32'(n_if.out), 32'h3456);

    // Random stream on both widths with random valid gaps.
    p1 = '{1'b0, 16'h0, 16'h0};
    p2 = p1;
    for (int c = 0; c < N_RAND + 2; c++) begin
      @(negedge clk);
      check("rand_valid_n", 32'(n_if.out_valid), 32'(p2.v));
      check("rand_valid_w", 32'(w_if.out_valid), 32'(p2.v));
      if (p2.v) begin
        check("rand_out_n", 32'(n_if.out), 32'(p2.en));
        check("rand_out_w", 32'(w_if.out), 32'(p2.ew));
      end
      if (c < N_RAND) begin
        pn.v = ($urandom_range(0, 3) != 0);
        n_if.in_valid = pn.v; w_if.in_valid = pn.v;
        n_if.ina = 16'($urandom); n_if.inb = 16'($urandom); n_if.ratio = 8'($urandom);
        w_if.ina = n_if.ina; w_if.inb = n_if.inb; w_if.ratio = 24'($urandom);
        pn.en = ref_lerp(n_if.ina, n_if.inb, 32'(n_if.ratio), F_N);
        pn.ew = ref_lerp(w_if.ina, w_if.inb, 32'(w_if.ratio), F_W);
      end else begin
        drive_idle();
        pn = '{1'b0, 16'h0, 16'h0};
      end
      p2 = p1;
      p1 = pn;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
